usb_fe_tx: RTL and testbench
============================

# usb_fe_tx

Synthesizable USB 2.0 FS/LS line transmitter for the front end. Takes a byte stream, one packet at a time, and drives the differential pair with the following, LSB first:
- SYNC;
- NRZI-encoded, bit-stuffed payload;
- EOP;
- enforced inter-packet gap.

It sits between the protocol engine and the `usb_fe_if` pads. It replaces the behavioural bit-banging with a clocked, parametrised serializer.

## Interface
Parameters:
- `CLK_DIV`, 4 — clocks per USB bit time (4 for 48 MHz FS). Must be ≥ 2.
- `LS_MODE`, 0 — line polarity.
  - 0: FS, J = dp 1 / dn 0.
  - 1: LS, J = dp 0 / dn 1.
- `EOP_SE0_BITS`, 2 — SE0 bit times in EOP.
- `IPG_BITS`, 6 — idle bit times after EOP before the next SYNC.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk  in  1` — clock.
  - `rst  in  1` — synchronous, active-high reset.
- Byte input:
  - `in_data  in  8` — packet byte. Bit 0 is sent first.
  - `in_valid  in  1` — byte available.
  - `in_last  in  1` — byte is the final byte of the packet.
  - `in_ready  out  1` — holding register empty. A byte transfers on `in_valid && in_ready`.
- Line outputs:
  - `dp_tx  out  1` — D+ drive level.
  - `dn_tx  out  1` — D- drive level.
  - `oe  out  1` — driver enable.
- Status:
  - `busy  out  1` — state ≠ IDLE.
  - `err_underrun  out  1` — one-clock pulse on underrun abort.

## Operation
- One-byte holding register (`hold`, `hold_last`, `hold_full`).
  - `in_ready = !hold_full`.
  - The shifter pulls from `hold` at each byte boundary.
- Bit strobe:
  - Counter `0..CLK_DIV-1`, cleared on leaving IDLE.
  - A strobe fires when the counter reaches `CLK_DIV-1`.
  - Every state advance and line change happens on a strobe, except the IDLE→SYNC start.
- FSM states: IDLE → SYNC → DATA → EOP_SE0 → EOP_J → GAP → IDLE.
  - **IDLE**: `oe`=0, line = J. When `hold_full`, go to SYNC; the first K appears the next clock.
  - **SYNC**: 8 bits, KJKJKJKK. On the last strobe, load `hold` into the shifter. The stuff counter is set to 1 because SYNC ends in a data 1.
  - **DATA**: NRZI encoding, where 0 toggles the line and 1 holds it.
    - After 6 consecutive 1s, insert one stuff bit (a toggle) and reset the counter to 0.
    - The stuff counter continues across byte boundaries.
    - After bit 7, one of three cases applies:
      - the byte was last: go to EOP_SE0, after any pending stuff bit;
      - otherwise, if `hold_full`: load the next byte;
      - otherwise: underrun.
  - **Underrun**:
    - Pulse `err_underrun`.
    - Send 8 J-holds (data 1s) with stuffing disabled, then go to EOP_SE0.
    - Flush `hold_full` on entry to EOP_SE0.
  - **EOP_SE0**: `EOP_SE0_BITS` bits of dp=dn=0.
  - **EOP_J**: 1 bit of J. Then `oe`=0.
  - **GAP**: `IPG_BITS` bit times, line J, `oe`=0. New bytes may fill `hold`, but SYNC does not start before GAP ends.
- `LS_MODE` swaps dp/dn for J/K only; SE0 is unaffected.

## Timing
- All outputs are registered.
- Reset values: `oe`=0, `dp_tx`/`dn_tx` = J, `busy`=0, `err_underrun`=0, `in_ready`=0 while `rst`=1. `in_ready`=1 on the first clock after.
- Start latency: `hold_full` in IDLE at edge n → `oe`=1 with K on edge n+1.
- Every bit, including stuff bits, lasts exactly `CLK_DIV` clocks.
- `oe` high duration = (8 + 8·N + stuffs + `EOP_SE0_BITS` + 1)·`CLK_DIV` clocks.
- `in_ready` falls the clock after a transfer. It rises the clock after the shifter loads.
- Input transfer and shifter load on the same clock: the load takes the old `hold` and the new byte is written. No loss.
- `rst` mid-packet: next clock `oe`=0, line J, state IDLE, `hold` flushed.
- `busy` stays high through GAP. Back-to-back packets are separated by exactly `IPG_BITS`·`CLK_DIV` clocks of `oe`=0.

## Test plan
- ACK packet, `CLK_DIV`=4, single byte 0xD2 with `in_last`:
  - line = KJKJKJKK JJKJJKKK SE0 SE0 J;
  - `oe` high 76 clocks; `err_underrun` never asserts.
- Bytes 0xFF, 0xFF:
  - stuff bits after byte 0 bit 4 and after byte 1 bit 2, 2 in total;
  - `oe` high 116 clocks.
- Single byte 0xFC: a stuff bit is sent after bit 7 before SE0; `oe` high 80 clocks.
- Two packets of 0xD2 queued back-to-back: exactly 24 clocks of `oe`=0 between the end of EOP J and the next K.
- First byte 0x00 without `in_last`, then `in_valid` held low:
  - `err_underrun` pulses once after byte 0;
  - 8 unstuffed J bits, then SE0 SE0 J.
- `LS_MODE`=1, byte 0xD2: dp/dn swapped for all J/K; SE0 identical.
- `rst` asserted during DATA: `oe`=0 and line J next clock; `in_ready`=1 after release.

Source files
------------

// File: rtl/usb_fe_tx_if.sv
// Byte-stream handshake between the protocol engine and the USB line transmitter.
interface usb_fe_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/usb_fe_tx.sv
// USB FS/LS line transmitter: SYNC, NRZI + bit-stuffed payload, EOP and
// inter-packet gap, one bit per CLK_DIV clocks, all outputs registered.
module usb_fe_tx #(
  parameter int unsigned CLK_DIV      = 4,     // clocks per bit time, >= 2
  parameter bit          LS_MODE      = 1'b0,  // 1 swaps dp/dn for J and K
  parameter int unsigned EOP_SE0_BITS = 2,     // >= 1
  parameter int unsigned IPG_BITS     = 6      // >= 1
) (
  input  logic       clk,
  input  logic       rst,
  usb_fe_tx_if.slave byte_if,
  output logic       dp_tx,
  output logic       dn_tx,
  output logic       oe,
  output logic       busy,
  output logic       err_underrun
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam logic LINE_J = 1'b1;
  localparam logic LINE_K = 1'b0;
  localparam logic J_DP   = ~LS_MODE;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_DATA, S_UNDER, S_EOP_SE0, S_EOP_J, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [7:0]      bcnt_q, bcnt_d;
  logic [2:0]      ones_q, ones_d;
  logic            line_q, line_d;
  logic            hold_full_q, hold_full_d;
  logic            in_ready_q;
  logic [7:0]      hold_q, shift_q;
  logic            hold_last_q, last_q;
  logic            dp_q, dp_d, dn_q, dn_d, oe_q, oe_d, busy_q, busy_d, err_q, err_d;
  logic            strobe, load, flush, wr, se0;
  logic [2:0]      nb;

  assign strobe           = (div_q == DW'(CLK_DIV - 1));
  assign wr               = byte_if.in_valid && in_ready_q;
  assign byte_if.in_ready = in_ready_q;
  assign dp_tx            = dp_q;
  assign dn_tx            = dn_q;
  assign oe               = oe_q;
  assign busy             = busy_q;
  assign err_underrun     = err_q;

  // State register plus handshake and registered line outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bcnt_q      <= '0;
      ones_q      <= '0;
      line_q      <= LINE_J;
      hold_full_q <= 1'b0;
      in_ready_q  <= 1'b0;
      dp_q        <= J_DP;
      dn_q        <= ~J_DP;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bcnt_q      <= bcnt_d;
      ones_q      <= ones_d;
      line_q      <= line_d;
      hold_full_q <= hold_full_d;
      in_ready_q  <= ~hold_full_d;
      dp_q        <= dp_d;
      dn_q        <= dn_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Byte holding register and shifter contents.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; they are only read after a load
    // qualified by reset-cleared control state.
    if (wr) begin
      hold_q      <= byte_if.in_data;
      hold_last_q <= byte_if.in_last;
    end
    if (load) begin
      shift_q <= hold_q;
      last_q  <= hold_last_q;
    end
  end

  // Next state: bit timing, SYNC pattern, NRZI/stuffing, byte hand-off, EOP and gap.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d = state_q;
    div_d   = '0;
    bcnt_d  = bcnt_q;
    ones_d  = ones_q;
    line_d  = line_q;
    err_d   = 1'b0;
    load    = 1'b0;
    flush   = 1'b0;
    nb      = bcnt_q[2:0] + 3'd1;
    if (state_q != S_IDLE && !strobe) div_d = div_q + DW'(1);

    case (state_q)
      S_IDLE: begin
        line_d = LINE_J;
        if (hold_full_q) begin
          state_d = S_SYNC;
          bcnt_d  = '0;
          line_d  = LINE_K;
        end
      end
      S_SYNC: if (strobe) begin
        if (bcnt_q == 8'd7) begin
          // SYNC ends in a data 1, so the first payload bit counts from one.
          state_d = S_DATA;
          load    = 1'b1;
          bcnt_d  = '0;
          line_d  = hold_q[0] ? line_q : ~line_q;
          ones_d  = hold_q[0] ? 3'd2 : 3'd0;
        end else begin
          bcnt_d = bcnt_q + 8'd1;
          line_d = (nb[0] && nb != 3'd7) ? LINE_J : LINE_K;
        end
      end
      S_DATA: if (strobe) begin
        if (ones_q == 3'd6) begin
          // Stuff bit takes precedence over the byte boundary and EOP.
          line_d = ~line_q;
          ones_d = '0;
        end else if (bcnt_q != 8'd7) begin
          bcnt_d = bcnt_q + 8'd1;
          line_d = shift_q[nb] ? line_q : ~line_q;
          ones_d = shift_q[nb] ? ones_q + 3'd1 : 3'd0;
        end else if (last_q) begin
          state_d = S_EOP_SE0;
          bcnt_d  = '0;
        end else if (hold_full_q) begin
          load   = 1'b1;
          bcnt_d = '0;
          line_d = hold_q[0] ? line_q : ~line_q;
          ones_d = hold_q[0] ? ones_q + 3'd1 : 3'd0;
        end else begin
          // Abort: a long unstuffed J run makes the receiver drop the packet.
          err_d   = 1'b1;
          state_d = S_UNDER;
          bcnt_d  = '0;
          line_d  = LINE_J;
        end
      end
      S_UNDER: if (strobe) begin
        if (bcnt_q == 8'd7) begin
          state_d = S_EOP_SE0;
          flush   = 1'b1;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      S_EOP_SE0: if (strobe) begin
        if (bcnt_q == 8'(EOP_SE0_BITS - 1)) begin
          state_d = S_EOP_J;
          bcnt_d  = '0;
          line_d  = LINE_J;
        end else begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      S_EOP_J: if (strobe) begin
        state_d = S_GAP;
        bcnt_d  = '0;
      end
      S_GAP: if (strobe) begin
        if (bcnt_q == 8'(IPG_BITS - 1)) begin
          // Going straight to SYNC keeps the gap at exactly IPG_BITS bit times.
          bcnt_d = '0;
          if (hold_full_q) begin
            state_d = S_SYNC;
            line_d  = LINE_K;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte written on the same clock as a load survives; an abort drops it.
    if (flush)            hold_full_d = 1'b0;
    else if (wr)          hold_full_d = 1'b1;
    else if (load)        hold_full_d = 1'b0;
    else                  hold_full_d = hold_full_q;
  end

  // Output decode from the next state so the pads change with the state.
  always_comb begin
    se0    = (state_d == S_EOP_SE0);
    oe_d   = !(state_d inside {S_IDLE, S_GAP});
    busy_d = (state_d != S_IDLE);
    dp_d   = se0 ? 1'b0 : (line_d ? J_DP : ~J_DP);
    dn_d   = se0 ? 1'b0 : (line_d ? ~J_DP : J_DP);
  end

endmodule

// File: tb/tb_usb_fe_tx.sv
// Directed bench for usb_fe_tx: FS and LS instances fed the same byte stream.
module tb_usb_fe_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_fe_tx_if bif();
  usb_fe_tx_if lif();
  assign lif.in_data  = bif.in_data;
  assign lif.in_valid = bif.in_valid;
  assign lif.in_last  = bif.in_last;

  logic dp, dn, oe, busy, err;
  logic ldp, ldn, loe, lbusy, lerr;

  usb_fe_tx #(.CLK_DIV(4), .LS_MODE(1'b0), .EOP_SE0_BITS(2), .IPG_BITS(6)) dut (
    .clk(clk), .rst(rst), .byte_if(bif),
    .dp_tx(dp), .dn_tx(dn), .oe(oe), .busy(busy), .err_underrun(err));

  usb_fe_tx #(.CLK_DIV(4), .LS_MODE(1'b1), .EOP_SE0_BITS(2), .IPG_BITS(6)) dut_ls (
    .clk(clk), .rst(rst), .byte_if(lif),
    .dp_tx(ldp), .dn_tx(ldn), .oe(loe), .busy(lbusy), .err_underrun(lerr));

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the most recent capture.
  int           c_clks, c_errs, c_rdy, c_lat, c_lsoe;
  logic [255:0] c_fs, c_ls, first_fs;
  int           gap, hi;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line symbols as {dp,dn} pairs, first symbol in the low bits; spaces ignored.
  function automatic logic [255:0] enc(input string s, input bit ls);
    logic [255:0] v;
    logic [1:0]   sym;
    int           n;
    v = '0;
    n = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] != " ") begin
        if (s[i] == "J")      sym = ls ? 2'b01 : 2'b10;
        else if (s[i] == "K") sym = ls ? 2'b10 : 2'b01;
        else                  sym = 2'b00;
        v[2*n +: 2] = sym;
        n++;
      end
    end
    return v;
  endfunction

  task automatic push(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    bif.in_data  = d;
    bif.in_last  = last;
    bif.in_valid = 1'b1;
    while (!bif.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", bif.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
  endtask

  // Waits for oe, then samples each bit mid-way until oe drops.
  task automatic capture();
    c_clks = 0; c_errs = 0; c_rdy = -1; c_lat = 0; c_lsoe = 0;
    c_fs = '0; c_ls = '0;
    while (!oe && c_lat < 2000) begin
      @(negedge clk);
      c_lat++;
    end
    check("oe_rise", oe, 1'b1);
    while (oe && c_clks < 2000) begin
      if (c_clks % 4 == 1 && c_clks < 512) begin
        c_fs[2*(c_clks/4) +: 2] = {dp, dn};
        c_ls[2*(c_clks/4) +: 2] = {ldp, ldn};
      end
      if (err) c_errs++;
      if (loe != oe) c_lsoe++;
      if (c_rdy < 0 && bif.in_ready) c_rdy = c_clks;
      c_clks++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    bif.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_oe", oe, 1'b0);
    check("rst_dp", dp, 1'b1);
    check("rst_dn", dn, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ready", bif.in_ready, 1'b0);
    check("rst_ls_line", {ldp, ldn, loe, lbusy, lerr, lif.in_ready}, 6'b010000);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bif.in_ready, 1'b1);

    // ACK 0xD2, plus LS polarity from the mirrored instance.
    push(8'hD2, 1'b1);
    check("ack_ready_fall", bif.in_ready, 1'b0);
    capture();
    check("ack_latency", c_lat, 1);
    check("ack_oe_clks", c_clks, 76);
    check("ack_line", c_fs, enc("KJKJKJKK JJKJJKKK 00J", 1'b0));
    check("ls_ack_line", c_ls, enc("KJKJKJKK JJKJJKKK 00J", 1'b1));
    check("ls_oe_match", c_lsoe, 0);
    check("ack_err", c_errs, 0);
    check("ack_ready_rise", c_rdy, 32);
    check("gap_busy_start", {busy, dp, dn}, 3'b110);
    repeat (23) @(negedge clk);
    check("gap_busy_end", busy, 1'b1);
    @(negedge clk);
    check("idle_after_gap", busy, 1'b0);

    // 0xFF 0xFF: stuff after byte 0 bit 4 and byte 1 bit 2.
    push(8'hFF, 1'b0);
    fork
      push(8'hFF, 1'b1);
      capture();
    join
    check("ff_oe_clks", c_clks, 116);
    check("ff_line", c_fs, enc("KJKJKJKK KKKKK J JJJ JJJ K KKKKK 00J", 1'b0));
    check("ff_err", c_errs, 0);
    wait_idle();

    // 0xFC: trailing stuff bit before SE0.
    push(8'hFC, 1'b1);
    capture();
    check("fc_oe_clks", c_clks, 80);
    check("fc_line", c_fs, enc("KJKJKJKK JK KKKKKK J 00J", 1'b0));
    wait_idle();

    // Back-to-back ACKs: gap of exactly 24 clocks.
    push(8'hD2, 1'b1);
    fork
      push(8'hD2, 1'b1);
      capture();
    join
    first_fs = c_fs;
    check("b2b_first_line", first_fs, enc("KJKJKJKK JJKJJKKK 00J", 1'b0));
    gap = 0;
    while (!oe && gap < 1000) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_gap", gap, 24);
    capture();
    check("b2b_second_oe", c_clks, 76);
    check("b2b_second_line", c_fs, enc("KJKJKJKK JJKJJKKK 00J", 1'b0));
    wait_idle();

    // Underrun: 0x00 without last, nothing follows.
    push(8'h00, 1'b0);
    capture();
    check("und_err_pulses", c_errs, 1);
    check("und_oe_clks", c_clks, 108);
    check("und_line", c_fs, enc("KJKJKJKK JKJKJKJK JJJJJJJJ 00J", 1'b0));
    wait_idle();
    check("und_ready", bif.in_ready, 1'b1);

    // Reset in DATA with a second byte waiting in hold.
    push(8'hD2, 1'b0);
    hi = 0;
    while (!oe && hi < 100) begin
      @(negedge clk);
      hi++;
    end
    check("rstmid_start", oe, 1'b1);
    push(8'h55, 1'b1);
    repeat (6) @(negedge clk);
    check("rstmid_in_data", {oe, bif.in_ready}, 2'b10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_line", {oe, dp, dn, busy}, 4'b0100);
    check("rstmid_ready", bif.in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready_after", bif.in_ready, 1'b1);
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (oe || busy) hi++;
    end
    check("rstmid_hold_flushed", hi, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
